// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state codes, BCD widths and the BCD increment helper for the stopwatch controller.
package stopwatch_ctrl_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam logic [1:0] SW_IDLE  = 2'd0;
    localparam logic [1:0] SW_RUN   = 2'd1;
    localparam logic [1:0] SW_PAUSE = 2'd2;
    localparam logic [1:0] SW_LAP   = 2'd3;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_ONES_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

    function automatic bcd_t bcd_next(input bcd_t q, input logic inc, input bcd_t max);
        bcd_t r;
        r = q;
        if (inc) begin
            r = (q == max) ? '0 : q + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD counter digit rolling over at MAX; carry feeds the next digit's increment.
module stopwatch_ctrl_bcd_digit
    import stopwatch_ctrl_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t q_q, q_d;

    always_comb begin
        q_d = clr ? '0 : bcd_next(q_q, inc, MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear stopwatch: 1 Hz prescaler, BCD MM:SS counter and lap-freeze display mux.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8000000,
    parameter int unsigned PRESC_W  = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_ss,
    input  logic             btn_clr,
    input  logic             btn_lap,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             running,
    output logic             lap_hold,
    output logic             tick,
    output logic             wrap
);

    logic               btn_ss_q, btn_clr_q, btn_lap_q;
    logic               ss_ev, clr_ev, lap_ev;
    logic [1:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               counting, presc_last, tick_w, enter_idle;
    bcd_t               so, st, mo, mt;
    logic               c_so, c_st, c_mo, c_mt;
    logic [15:0]        live, live_next;
    logic [15:0]        lap_latch_q, lap_latch_d;
    logic [15:0]        disp_q, disp_d;

    assign ss_ev  = btn_ss & ~btn_ss_q;
    assign clr_ev = btn_clr & ~btn_clr_q;
    assign lap_ev = btn_lap & ~btn_lap_q;

    assign counting   = (state_q == SW_RUN) || (state_q == SW_LAP);
    assign presc_last = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign tick_w     = counting & presc_last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SW_IDLE:  if (ss_ev) state_d = SW_RUN;
            SW_RUN:   if (ss_ev) state_d = SW_PAUSE; else if (lap_ev) state_d = SW_LAP;
            SW_LAP:   if (ss_ev) state_d = SW_PAUSE; else if (lap_ev) state_d = SW_RUN;
            SW_PAUSE: if (clr_ev) state_d = SW_IDLE; else if (ss_ev) state_d = SW_RUN;
            default:  state_d = SW_IDLE;
        endcase
    end

    assign enter_idle = (state_q != SW_IDLE) && (state_d == SW_IDLE);

    always_comb begin
        presc_d = presc_q;
        if (enter_idle) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = presc_last ? '0 : presc_q + 1'b1;
        end
    end

    stopwatch_ctrl_bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(enter_idle), .inc(tick_w), .q(so), .carry(c_so)
    );
    stopwatch_ctrl_bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(enter_idle), .inc(c_so), .q(st), .carry(c_st)
    );
    stopwatch_ctrl_bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(enter_idle), .inc(c_st), .q(mo), .carry(c_mo)
    );
    stopwatch_ctrl_bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(enter_idle), .inc(c_mo), .q(mt), .carry(c_mt)
    );

    assign live = {mt, mo, st, so};
    // Lap captures the time as it will be after this edge, so a coincident tick is included.
    assign live_next = {bcd_next(mt, c_mo, MIN_TENS_MAX), bcd_next(mo, c_st, MIN_ONES_MAX),
                        bcd_next(st, c_so, SEC_TENS_MAX), bcd_next(so, tick_w, SEC_ONES_MAX)};

    always_comb begin
        lap_latch_d = lap_latch_q;
        if ((state_q == SW_RUN) && (state_d == SW_LAP)) begin
            lap_latch_d = live_next;
        end
        disp_d = (state_q == SW_LAP) ? lap_latch_q : live;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_ss_q    <= 1'b0;
            btn_clr_q   <= 1'b0;
            btn_lap_q   <= 1'b0;
            state_q     <= SW_IDLE;
            presc_q     <= '0;
            lap_latch_q <= '0;
            disp_q      <= '0;
        end else begin
            btn_ss_q    <= btn_ss;
            btn_clr_q   <= btn_clr;
            btn_lap_q   <= btn_lap;
            state_q     <= state_d;
            presc_q     <= presc_d;
            lap_latch_q <= lap_latch_d;
            disp_q      <= disp_d;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = disp_q;
    assign running  = counting;
    assign lap_hold = (state_q == SW_LAP);
    assign tick     = tick_w;
    assign wrap     = c_mt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4: run, pause phase, lap freeze, wrap, clear, reset.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_hold, tick, wrap;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(4), .PRESC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .lap_hold(lap_hold), .tick(tick), .wrap(wrap)
    );

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Raise the chosen buttons for one cycle; the event lands on the second posedge.
    task automatic press(input logic ss, input logic clr, input logic lap);
        @(posedge clk);
        #1;
        btn_ss  = ss;
        btn_clr = clr;
        btn_lap = lap;
        @(posedge clk);
        #1;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
    endtask

    // Returns at the negedge on which the n-th tick is visible.
    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < n * 4 + 20) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        check("wait_ticks", seen, n);
    endtask

    task automatic settle_disp();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int changes;
        logic prev;

        // 1: reset state, start, tick period, 12 s
        do_reset();
        check("rst_disp", disp(), 16'h0000);
        check("rst_running", running, 0);
        check("rst_lap_hold", lap_hold, 0);
        check("rst_tick", tick, 0);
        check("rst_wrap", wrap, 0);
        press(1, 0, 0);
        @(negedge clk);
        check("t1_running", running, 1);
        wait_ticks(1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick && k < 10);
        check("t1_tick_period", k, 4);
        wait_ticks(10);
        settle_disp();
        check("t1_disp_12", disp(), 16'h0012);

        // 2: pause keeps sub-second phase
        do_reset();
        press(1, 0, 0);
        wait_ticks(7);
        press(1, 0, 0);
        k = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) k++;
        end
        check("t2_no_ticks_paused", k, 0);
        check("t2_disp_paused", disp(), 16'h0007);
        check("t2_running_paused", running, 0);
        press(1, 0, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick && k < 10);
        check("t2_resume_phase", k, 3);

        // 3: lap freeze and release
        do_reset();
        press(1, 0, 0);
        wait_ticks(10);
        press(0, 0, 1);
        @(negedge clk);
        check("t3_lap_hold", lap_hold, 1);
        check("t3_running_lap", running, 1);
        wait_ticks(5);
        check("t3_frozen", disp(), 16'h0010);
        press(0, 0, 1);
        @(negedge clk);
        check("t3_lap_release", lap_hold, 0);
        @(posedge clk);
        @(negedge clk);
        check("t3_disp_live", disp(), 16'h0015);

        // 4: rollover 59:59 -> 00:00
        do_reset();
        press(1, 0, 0);
        wait_ticks(3598);
        settle_disp();
        check("t4_disp_5958", disp(), 16'h5958);
        wait_ticks(1);
        check("t4_no_wrap_early", wrap, 0);
        settle_disp();
        check("t4_disp_5959", disp(), 16'h5959);
        wait_ticks(1);
        check("t4_wrap_pulse", wrap, 1);
        settle_disp();
        check("t4_disp_0000", disp(), 16'h0000);
        check("t4_wrap_done", wrap, 0);

        // 5: clear beats start/stop in PAUSE; clear ignored in RUN
        do_reset();
        press(1, 0, 0);
        wait_ticks(201);
        press(1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_disp_0321", disp(), 16'h0321);
        press(1, 1, 0);
        @(negedge clk);
        check("t5_idle_running", running, 0);
        @(posedge clk);
        @(negedge clk);
        check("t5_disp_cleared", disp(), 16'h0000);
        press(1, 0, 0);
        wait_ticks(2);
        press(0, 1, 0);
        @(negedge clk);
        check("t5_clr_in_run", running, 1);
        wait_ticks(1);
        settle_disp();
        check("t5_keeps_counting", disp(), 16'h0003);

        // 6: held button gives one event; async reset mid-run
        do_reset();
        prev    = running;
        changes = 0;
        @(posedge clk);
        #1 btn_ss = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (running != prev) changes++;
            prev = running;
        end
        btn_ss = 1'b0;
        check("t6_one_change", changes, 1);
        check("t6_running", running, 1);
        wait_ticks(3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_disp", disp(), 16'h0000);
        check("t6_async_running", running, 0);
        check("t6_async_tick", tick, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t6_stays_idle", running, 0);
        check("t6_disp_idle", disp(), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
